// File: rtl/mux_n_sync.sv
// rtl/mux_n_sync.sv - clocked M-way 4-phase req/ack channel mux with select channel
// Steers input channel s_d to a registered output; out-of-range selects set sticky err.
module mux_n_sync #(
   parameter int N = 32,
   parameter int M = 4,
   localparam int SW = (M > 2) ? $clog2(M) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           r_s,
   output logic           a_s,
   input  logic [SW-1:0]  s_d,
   input  logic [M-1:0]   r_i,
   output logic [M-1:0]   a_i,
   input  logic [M*N-1:0] d_i,
   output logic           r_o,
   input  logic           a_o,
   output logic [N-1:0]   d_o,
   output logic           err
);

   typedef enum logic [1:0] {IDLE, SEND, RELEASE, DROP} state_t;

   // Out-of-range selects exist only when M is not a power of two.
   localparam bit          HAS_OOR = ((1 << SW) != M);
   localparam logic [SW:0] M_L     = (SW + 1)'(M);

   state_t          state_q, state_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            a_s_q, a_s_d;
   logic [M-1:0]    a_i_q, a_i_d;
   logic            r_o_q, r_o_d;
   logic [N-1:0]    d_o_q, d_o_d;
   logic            err_q, err_d;

   logic            req_s;
   logic [N-1:0]    data_s;
   logic            req_sel;
   logic [M-1:0]    sel_onehot;
   logic            oor;

   always_comb begin
      req_s      = 1'b0;
      data_s     = '0;
      req_sel    = 1'b0;
      sel_onehot = '0;
      for (int k = 0; k < M; k++) begin
         if (s_d == SW'(k)) begin
            req_s  = r_i[k];
            data_s = d_i[k*N +: N];
         end
         if (sel_q == SW'(k)) begin
            req_sel       = r_i[k];
            sel_onehot[k] = 1'b1;
         end
      end
      oor = HAS_OOR && ({1'b0, s_d} >= M_L);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      a_s_d   = a_s_q;
      a_i_d   = a_i_q;
      r_o_d   = r_o_q;
      d_o_d   = d_o_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (r_s) begin
               if (oor) begin
                  a_s_d   = 1'b1;
                  err_d   = 1'b1;
                  state_d = DROP;
               end else if (req_s) begin
                  d_o_d   = data_s;
                  sel_d   = s_d;
                  r_o_d   = 1'b1;
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (a_o) begin
               r_o_d   = 1'b0;
               a_i_d   = sel_onehot;
               a_s_d   = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // All three return-to-zero phases must be seen in the same cycle.
            if (!req_sel && !r_s && !a_o) begin
               a_i_d   = '0;
               a_s_d   = 1'b0;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (!r_s) begin
               a_s_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         a_s_q   <= 1'b0;
         a_i_q   <= '0;
         r_o_q   <= 1'b0;
         d_o_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         a_s_q   <= a_s_d;
         a_i_q   <= a_i_d;
         r_o_q   <= r_o_d;
         d_o_q   <= d_o_d;
         err_q   <= err_d;
      end
   end

   assign a_s = a_s_q;
   assign a_i = a_i_q;
   assign r_o = r_o_q;
   assign d_o = d_o_q;
   assign err = err_q;

endmodule

// File: tb/tb_mux_n_sync.sv
// tb/tb_mux_n_sync.sv - directed bench for mux_n_sync with M=4 and M=3 instances
module tb_mux_n_sync;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         r_s4, a_s4, r_o4, a_o4, err4;
   logic [1:0]   s_d4;
   logic [3:0]   r_i4, a_i4;
   logic [127:0] d_i4;
   logic [31:0]  d_o4;

   logic         r_s3, a_s3, r_o3, a_o3, err3;
   logic [1:0]   s_d3;
   logic [2:0]   r_i3, a_i3;
   logic [95:0]  d_i3;
   logic [31:0]  d_o3;

   mux_n_sync #(.N(32), .M(4)) u4 (
      .clk(clk), .rst(rst), .r_s(r_s4), .a_s(a_s4), .s_d(s_d4), .r_i(r_i4), .a_i(a_i4),
      .d_i(d_i4), .r_o(r_o4), .a_o(a_o4), .d_o(d_o4), .err(err4)
   );

   mux_n_sync #(.N(32), .M(3)) u3 (
      .clk(clk), .rst(rst), .r_s(r_s3), .a_s(a_s3), .s_d(s_d3), .r_i(r_i3), .a_i(a_i3),
      .d_i(d_i3), .r_o(r_o3), .a_o(a_o3), .d_o(d_o3), .err(err3)
   );

   int tests = 0;
   int fails = 0;
   int onehot_bad = 0;

   always @(negedge clk) begin
      if (!rst && (($countones(a_i4) > 1) || ($countones(a_i3) > 1)))
         onehot_bad++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        r_s;
      logic [1:0]  s_d;
      logic [3:0]  r_i;
      logic        a_o;
      logic        r_o;
      logic [3:0]  a_i;
      logic        a_s;
      logic [31:0] d_o;
   } vec_t;

   vec_t tbl[13];

   localparam logic [31:0] CH0 = 32'h1111_0000;
   localparam logic [31:0] CH1 = 32'h2222_1111;
   localparam logic [31:0] CH2 = 32'hDEAD_BEEF;
   localparam logic [31:0] CH3 = 32'h3333_4444;

   int          sel;
   int          dly;
   logic [31:0] v;
   logic        seen;

   initial begin
      tbl[0]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 2'd2, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, CH2};
      tbl[2]  = '{1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, CH2};
      tbl[3]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, CH2};
      tbl[4]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, CH2};
      tbl[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, CH2};
      tbl[6]  = '{1'b1, 2'd1, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, CH1};
      tbl[7]  = '{1'b1, 2'd1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, CH1};
      tbl[8]  = '{1'b0, 2'd1, 4'b1101, 1'b0, 1'b0, 4'b0000, 1'b0, CH1};
      tbl[9]  = '{1'b1, 2'd3, 4'b1101, 1'b0, 1'b1, 4'b0000, 1'b0, CH3};
      tbl[10] = '{1'b1, 2'd3, 4'b1101, 1'b1, 1'b0, 4'b1000, 1'b1, CH3};
      tbl[11] = '{1'b0, 2'd3, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, CH3};
      tbl[12] = '{1'b0, 2'd0, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0, CH3};

      rst  = 1'b1;
      r_s4 = 1'b0; s_d4 = 2'd0; r_i4 = '0; a_o4 = 1'b0;
      d_i4 = {CH3, CH2, CH1, CH0};
      r_s3 = 1'b0; s_d3 = 2'd0; r_i3 = '0; a_o3 = 1'b0;
      d_i3 = {32'hC3C3_0002, 32'hA5A5_0001, 32'h5A5A_0000};
      tick;
      tick;
      chk("reset_u4", {27'd0, r_o4, a_i4, a_s4, err4, d_o4}, 64'd0);
      chk("reset_u3", {28'd0, r_o3, a_i3, a_s3, err3, d_o3}, 64'd0);
      rst = 1'b0;

      // Basic and competing transfers
      for (int i = 0; i < 13; i++) begin
         r_s4 = tbl[i].r_s; s_d4 = tbl[i].s_d; r_i4 = tbl[i].r_i; a_o4 = tbl[i].a_o;
         tick;
         chk($sformatf("vec%0d", i), {26'd0, r_o4, a_i4, a_s4, err4, d_o4},
             {26'd0, tbl[i].r_o, tbl[i].a_i, tbl[i].a_s, 1'b0, tbl[i].d_o});
      end

      // Select waits indefinitely for its data channel
      r_s4 = 1'b1; s_d4 = 2'd0; r_i4 = 4'b0000; a_o4 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("wait_ro_low", {63'd0, r_o4}, 64'd0);
      end
      r_i4 = 4'b0001;
      tick;
      chk("wait_capture", {31'd0, r_o4, d_o4}, {31'd0, 1'b1, CH0});
      a_o4 = 1'b1;
      tick;
      chk("wait_ack", {58'd0, a_s4, a_i4, r_o4}, {58'd0, 1'b1, 4'b0001, 1'b0});
      r_s4 = 1'b0; r_i4 = 4'b0000; a_o4 = 1'b0;
      tick;
      chk("wait_release", {59'd0, a_s4, a_i4}, 64'd0);

      // Asynchronous reset in the middle of SEND
      r_s4 = 1'b1; s_d4 = 2'd2; r_i4 = 4'b0100;
      tick;
      chk("rst_pre_send", {31'd0, r_o4, d_o4}, {31'd0, 1'b1, CH2});
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {27'd0, r_o4, a_i4, a_s4, err4, d_o4}, 64'd0);
      tick;
      rst = 1'b0; r_s4 = 1'b0; r_i4 = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_no_ack", {58'd0, r_o4, a_i4, a_s4}, 64'd0);
      end

      // Out-of-range select on the M=3 instance
      r_s3 = 1'b1; s_d3 = 2'd3; r_i3 = 3'b111;
      tick;
      chk("oor_drop", {58'd0, a_s3, err3, r_o3, a_i3}, {58'd0, 1'b1, 1'b1, 1'b0, 3'b000});
      repeat (3) tick;
      chk("oor_hold", {58'd0, a_s3, err3, r_o3, a_i3}, {58'd0, 1'b1, 1'b1, 1'b0, 3'b000});
      r_s3 = 1'b0;
      tick;
      chk("oor_release", {58'd0, a_s3, err3, r_o3, a_i3}, {58'd0, 1'b0, 1'b1, 1'b0, 3'b000});
      r_s3 = 1'b1; s_d3 = 2'd1;
      tick;
      chk("oor_next_capture", {30'd0, r_o3, err3, d_o3}, {30'd0, 1'b1, 1'b1, 32'hA5A5_0001});
      a_o3 = 1'b1;
      tick;
      chk("oor_next_ack", {59'd0, a_s3, err3, a_i3}, {59'd0, 1'b1, 1'b1, 3'b010});
      r_s3 = 1'b0; r_i3 = 3'b000; a_o3 = 1'b0;
      tick;
      chk("oor_err_sticky", {59'd0, a_s3, err3, a_i3}, {59'd0, 1'b0, 1'b1, 3'b000});

      // Back-to-back transfers with a slow consumer
      for (int t = 0; t < 8; t++) begin
         sel = t % 4;
         v   = $urandom;
         dly = $urandom_range(0, 5);
         d_i4[sel*32 +: 32] = v;
         r_s4 = 1'b1; s_d4 = sel[1:0]; r_i4 = 4'b0001 << sel;
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            tick;
            seen = r_o4;
         end
         chk($sformatf("b2b%0d_ro", t), {63'd0, seen}, 64'd1);
         chk($sformatf("b2b%0d_data", t), {32'd0, d_o4}, {32'd0, v});
         repeat (dly) tick;
         chk($sformatf("b2b%0d_hold", t), {31'd0, r_o4, d_o4}, {31'd0, 1'b1, v});
         a_o4 = 1'b1;
         tick;
         chk($sformatf("b2b%0d_ack", t), {59'd0, a_s4, a_i4}, {59'd0, 1'b1, 4'b0001 << sel});
         r_s4 = 1'b0; r_i4 = 4'b0000; a_o4 = 1'b0;
         tick;
         chk($sformatf("b2b%0d_rel", t), {58'd0, a_s4, a_i4, r_o4}, 64'd0);
      end

      chk("ai_onehot", 64'(onehot_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
